// File: rtl/cache_controller.sv
// cache_controller: decodes processor hits and sequences dirty writeback plus line refill for one set array.
// Define CACHE_PERF_CNT_EN to add saturating hit/miss counters; otherwise both count ports read 0.
`ifndef CACHE_S
 `define CACHE_S 4
`endif
`ifndef CACHE_T
 `define CACHE_T 24
`endif
`ifndef CACHE_B
 `define CACHE_B 4
`endif

module cache_controller #(
   parameter int SET_WIDTH    = `CACHE_S,
   parameter int TAG_WIDTH    = `CACHE_T,
   parameter int OFFSET_WIDTH = `CACHE_B
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req,
   input  logic                    req_we,
   input  logic [31:0]             addr,
   input  logic                    set_hit,
   input  logic                    set_dirty_in,
   input  logic [TAG_WIDTH-1:0]    set_tag,
   input  logic [31:0]             set_rdata,
   input  logic                    mem_ready,
   output logic                    stall,
   output logic                    set_en,
   output logic                    set_wen,
   output logic                    set_valid,
   output logic                    set_dirty,
   output logic [OFFSET_WIDTH-3:0] set_offset,
   output logic                    set_offset_sel,
   output logic                    set_strategy_en,
   output logic                    mem_ren,
   output logic                    mem_wen,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
);

   localparam int WW = OFFSET_WIDTH - 2;
   localparam logic [WW-1:0] LAST = '1;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t                 state, state_next;
   logic [WW-1:0]          cnt;
   logic [TAG_WIDTH-1:0]   victim_tag, miss_tag;
   logic [SET_WIDTH-1:0]   miss_set;
   logic                   miss_detect, word_done;

   // Miss addressing is captured at detection so a dropped request cannot corrupt an in-flight line
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         victim_tag <= '0;
         miss_tag   <= '0;
         miss_set   <= '0;
      end else begin
         state <= state_next;
         if (miss_detect) begin
            cnt        <= '0;
            victim_tag <= set_tag;
            miss_tag   <= addr[31 -: TAG_WIDTH];
            miss_set   <= addr[OFFSET_WIDTH +: SET_WIDTH];
         end else if (word_done) begin
            cnt <= cnt + WW'(1);
         end
      end
   end

   always_comb begin
      state_next      = state;
      miss_detect     = 1'b0;
      word_done       = 1'b0;
      stall           = 1'b0;
      set_en          = 1'b0;
      set_wen         = 1'b0;
      set_valid       = 1'b0;
      set_dirty       = 1'b0;
      set_offset      = '0;
      set_offset_sel  = 1'b0;
      set_strategy_en = 1'b0;
      mem_ren         = 1'b0;
      mem_wen         = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;
      case (state)
         IDLE: begin
            if (req) begin
               set_offset = addr[OFFSET_WIDTH-1:2];
               if (set_hit) begin
                  set_en          = 1'b1;
                  set_strategy_en = 1'b1;
                  if (req_we) begin
                     set_wen   = 1'b1;
                     set_valid = 1'b1;
                     set_dirty = 1'b1;
                  end
               end else begin
                  stall       = 1'b1;
                  miss_detect = 1'b1;
                  state_next  = set_dirty_in ? WRITEBACK : REFILL;
               end
            end
         end
         WRITEBACK: begin
            stall      = 1'b1;
            mem_wen    = 1'b1;
            mem_addr   = {victim_tag, miss_set, cnt, 2'b00};
            mem_wdata  = set_rdata;
            set_offset = cnt;
            set_en     = 1'b1;
            if (mem_ready) begin
               word_done = 1'b1;
               if (cnt == LAST) state_next = REFILL;
            end
         end
         REFILL: begin
            stall      = 1'b1;
            mem_ren    = 1'b1;
            mem_addr   = {miss_tag, miss_set, cnt, 2'b00};
            set_offset = cnt;
            if (mem_ready) begin
               set_en         = 1'b1;
               set_wen        = 1'b1;
               set_offset_sel = 1'b1;
               set_valid      = 1'b1;
               word_done      = 1'b1;
               if (cnt == LAST) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef CACHE_PERF_CNT_EN
   // Both counters stick at all-ones rather than wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (state == IDLE && req && set_hit && hit_count != '1) hit_count <= hit_count + 32'd1;
         if (miss_detect && miss_count != '1) miss_count <= miss_count + 32'd1;
      end
   end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: decode vector table, directed miss/reset sequences,
// and randomized traffic scored against a queue-of-memory-operations reference model.
module tb_cache_controller;

   localparam int SW = 4;
   localparam int TW = 24;
   localparam int OW = 4;
   localparam int WORDS = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req, req_we, set_hit, set_dirty_in, mem_ready;
   logic [31:0]   addr, set_rdata;
   logic [TW-1:0] set_tag;
   logic          stall, set_en, set_wen, set_valid, set_dirty, set_offset_sel, set_strategy_en;
   logic [OW-3:0] set_offset;
   logic          mem_ren, mem_wen;
   logic [31:0]   mem_addr, mem_wdata, hit_count, miss_count;

   cache_controller #(.SET_WIDTH(SW), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .addr(addr),
      .set_hit(set_hit), .set_dirty_in(set_dirty_in), .set_tag(set_tag), .set_rdata(set_rdata),
      .mem_ready(mem_ready), .stall(stall), .set_en(set_en), .set_wen(set_wen),
      .set_valid(set_valid), .set_dirty(set_dirty), .set_offset(set_offset),
      .set_offset_sel(set_offset_sel), .set_strategy_en(set_strategy_en),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] a;
      logic [1:0]  word;
   } op_t;

   typedef struct {
      logic        req, we, hit;
      logic [31:0] addr;
      logic        e_stall, e_en, e_wen, e_valid, e_dirty, e_strat;
      logic [1:0]  e_off;
   } tv_t;

   op_t         q[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] m_hits = 0;
   logic [31:0] m_misses = 0;
   int          wenPulses, stallCycles;
   logic [1:0]  offLog[$];
   logic [31:0] raddrLog[$], waddrLog[$];
   tv_t         tv[7];
   logic        rReq, rWe, rHit, busy, recompare;
   logic [31:0] rAddr;

   // Watchdog so a wedged run still terminates
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: idle decode when no memory operations are pending, otherwise the head operation
   task automatic checkOutput();
      logic e_stall = 0, e_en = 0, e_wen = 0, e_valid = 0, e_dirty = 0, e_sel = 0, e_strat = 0;
      logic e_ren = 0, e_mwen = 0;
      logic [1:0]  e_off = 0;
      logic [31:0] e_maddr = 0, e_wdata = 0;
      if (q.size() == 0) begin
         if (req) begin
            if (set_hit) begin
               e_en = 1; e_strat = 1; e_off = addr[3:2];
               if (req_we) begin e_wen = 1; e_valid = 1; e_dirty = 1; end
            end else begin
               e_stall = 1;
            end
         end
      end else begin
         e_stall = 1; e_maddr = q[0].a; e_off = q[0].word;
         if (q[0].wr) begin
            e_mwen = 1; e_wdata = set_rdata; e_en = 1;
         end else begin
            e_ren = 1;
            if (mem_ready) begin e_en = 1; e_wen = 1; e_sel = 1; e_valid = 1; end
         end
      end
      cmp("stall", stall, e_stall);
      cmp("set_en", set_en, e_en);
      cmp("set_wen", set_wen, e_wen);
      cmp("set_valid", set_valid, e_valid);
      cmp("set_dirty", set_dirty, e_dirty);
      cmp("set_offset_sel", set_offset_sel, e_sel);
      cmp("set_strategy_en", set_strategy_en, e_strat);
      cmp("mem_ren", mem_ren, e_ren);
      cmp("mem_wen", mem_wen, e_mwen);
      if (e_en) cmp("set_offset", set_offset, e_off);
      if (e_ren || e_mwen) cmp("mem_addr", mem_addr, e_maddr);
      if (e_mwen) cmp("mem_wdata", mem_wdata, e_wdata);
`ifdef CACHE_PERF_CNT_EN
      cmp("hit_count", hit_count, m_hits);
      cmp("miss_count", miss_count, m_misses);
`else
      cmp("hit_count", hit_count, 0);
      cmp("miss_count", miss_count, 0);
`endif
      if (set_wen) begin wenPulses++; offLog.push_back(set_offset); end
      if (stall) stallCycles++;
      if (mem_ren && mem_ready) raddrLog.push_back(mem_addr);
      if (mem_wen && mem_ready) waddrLog.push_back(mem_addr);
   endtask

   task automatic updateModel();
      op_t o;
      if (reset) begin
         q.delete(); m_hits = 0; m_misses = 0;
      end else if (q.size() == 0) begin
         if (req && set_hit) begin
            if (m_hits != 32'hFFFF_FFFF) m_hits++;
         end else if (req) begin
            if (m_misses != 32'hFFFF_FFFF) m_misses++;
            if (set_dirty_in)
               for (int w = 0; w < WORDS; w++) begin
                  o.wr = 1; o.word = 2'(w);
                  o.a = (32'(set_tag) << 8) | (addr & 32'h0000_00F0) | 32'(w * 4);
                  q.push_back(o);
               end
            for (int w = 0; w < WORDS; w++) begin
               o.wr = 0; o.word = 2'(w);
               o.a = (addr & 32'hFFFF_FFF0) | 32'(w * 4);
               q.push_back(o);
            end
         end
      end else if (mem_ready) begin
         void'(q.pop_front());
      end
   endtask

   task automatic applyStimulus(input logic r, input logic we, input logic [31:0] a, input logic hit,
                                input logic dirty, input logic [TW-1:0] tag, input logic rdy);
      @(negedge clk);
      req = r; req_we = we; addr = a; set_hit = hit; set_dirty_in = dirty;
      set_tag = tag; set_rdata = $urandom; mem_ready = rdy;
      #1 checkOutput();
      @(posedge clk);
      updateModel();
   endtask

   task automatic runMiss(input logic [31:0] a, input logic we, input logic dirty,
                          input logic [TW-1:0] vtag, input int period);
      int k = 0;
      wenPulses = 0; stallCycles = 0;
      offLog.delete(); raddrLog.delete(); waddrLog.delete();
      applyStimulus(1, we, a, 0, dirty, vtag, 0);
      while (q.size() > 0 && k < 200) begin
         applyStimulus(1, we, a, 0, 1'($urandom), TW'($urandom), (k % period) == period - 1);
         k++;
      end
      if (q.size() > 0) begin
         total++; bad++;
         $display("[TB] FAIL miss_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end else begin
         applyStimulus(1, we, a, 1, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1; req = 0; req_we = 0; addr = 0; set_hit = 0; set_dirty_in = 0;
      set_tag = 0; set_rdata = 0; mem_ready = 0;
      #1 checkOutput();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 0;

      // IDLE decode vectors; req is dropped before each edge so no miss is launched
      tv[0] = '{0, 0, 0, 32'h0000_0104, 0, 0, 0, 0, 0, 0, 2'd0};
      tv[1] = '{1, 0, 1, 32'h0000_0104, 0, 1, 0, 0, 0, 1, 2'd1};
      tv[2] = '{1, 1, 1, 32'h0000_010C, 0, 1, 1, 1, 1, 1, 2'd3};
      tv[3] = '{1, 0, 0, 32'h0000_2008, 1, 0, 0, 0, 0, 0, 2'd0};
      tv[4] = '{1, 1, 0, 32'h0000_2008, 1, 0, 0, 0, 0, 0, 2'd0};
      tv[5] = '{0, 1, 1, 32'h0000_0108, 0, 0, 0, 0, 0, 0, 2'd0};
      tv[6] = '{1, 0, 1, 32'h0000_0000, 0, 1, 0, 0, 0, 1, 2'd0};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         req = tv[i].req; req_we = tv[i].we; set_hit = tv[i].hit; addr = tv[i].addr;
         set_dirty_in = 0; mem_ready = 1;
         #1;
         cmp($sformatf("tv%0d_stall", i), stall, tv[i].e_stall);
         cmp($sformatf("tv%0d_set_en", i), set_en, tv[i].e_en);
         cmp($sformatf("tv%0d_set_wen", i), set_wen, tv[i].e_wen);
         cmp($sformatf("tv%0d_set_valid", i), set_valid, tv[i].e_valid);
         cmp($sformatf("tv%0d_set_dirty", i), set_dirty, tv[i].e_dirty);
         cmp($sformatf("tv%0d_strategy", i), set_strategy_en, tv[i].e_strat);
         cmp($sformatf("tv%0d_mem_req", i), {mem_ren, mem_wen}, 0);
         if (tv[i].e_en) cmp($sformatf("tv%0d_offset", i), set_offset, tv[i].e_off);
         #1 req = 0;
      end

      // Store hit strobes for one cycle only
      wenPulses = 0;
      applyStimulus(1, 1, 32'h0000_0104, 1, 0, 0, 0);
      applyStimulus(0, 0, 32'h0000_0104, 1, 0, 0, 0);
      cmp("store_hit_pulses", wenPulses, 1);

      // Clean miss, memory ready every second cycle
      runMiss(32'h0000_2008, 0, 0, 24'h0, 2);
      cmp("clean_wen_pulses", wenPulses, 4);
      cmp("clean_stall_cycles", stallCycles, 9);
      cmp("clean_raddr_count", raddrLog.size(), 4);
      for (int i = 0; i < 4 && i < raddrLog.size(); i++)
         cmp($sformatf("clean_raddr%0d", i), raddrLog[i], 32'h0000_2000 + 32'(4 * i));
      for (int i = 0; i < 4 && i < offLog.size(); i++)
         cmp($sformatf("clean_off%0d", i), offLog[i], i);

      // Dirty store miss: victim tag 1, set 0
      runMiss(32'h0000_2004, 1, 1, 24'h1, 1);
      cmp("dirty_waddr_count", waddrLog.size(), 4);
      cmp("dirty_raddr_count", raddrLog.size(), 4);
      for (int i = 0; i < 4 && i < waddrLog.size(); i++)
         cmp($sformatf("dirty_waddr%0d", i), waddrLog[i], 32'h0000_0100 + 32'(4 * i));
      for (int i = 0; i < 4 && i < raddrLog.size(); i++)
         cmp($sformatf("dirty_raddr%0d", i), raddrLog[i], 32'h0000_2000 + 32'(4 * i));
      cmp("dirty_wen_pulses", wenPulses, 5);

      // Reset while the third refill word is on the bus
      applyStimulus(1, 0, 32'h0000_2008, 0, 0, 0, 0);
      applyStimulus(1, 0, 32'h0000_2008, 0, 0, 0, 1);
      applyStimulus(1, 0, 32'h0000_2008, 0, 0, 0, 1);
      @(negedge clk);
      req = 0; mem_ready = 0;
      #1 checkOutput();
      reset = 1;
      #1;
      cmp("rst_mem_ren", mem_ren, 0);
      cmp("rst_mem_wen", mem_wen, 0);
      cmp("rst_stall", stall, 0);
      cmp("rst_set_wen", set_wen, 0);
      q.delete(); m_hits = 0; m_misses = 0;
      @(negedge clk) reset = 0;
      applyStimulus(1, 0, 32'h0000_0104, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic against the operation-queue model
      recompare = 0; rReq = 0; rWe = 0; rAddr = 0; rHit = 0;
      for (int c = 0; c < 1500; c++) begin
         if (q.size() == 0) begin
            if (recompare) begin
               rHit = 1; recompare = 0;
            end else begin
               rReq = $urandom_range(0, 3) != 0;
               rWe = 1'($urandom);
               rAddr = $urandom;
               rHit = 1'($urandom);
            end
         end else begin
            rHit = 0;
         end
         busy = q.size() > 0;
         applyStimulus(rReq, rWe, rAddr, rHit, 1'($urandom), TW'($urandom), $urandom_range(0, 2) == 0);
         if (busy && q.size() == 0) recompare = 1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
